pwm_mode_ctrl: RTL
==================

# pwm_mode_ctrl

Parametrised multi-channel PWM pattern controller for the board LED/servo outputs. It combines a prescaler, an R-bit PWM counter, a pattern engine, and per-channel PWM comparators. The pattern engine implements linear ramp, triangle breathe, rainbow hue sweep, and servo sweep. Mode comes from priority-decoded switches, synchronised on entry, and is applied only at PWM period boundaries, so outputs never glitch.

## Interface
- CH, 3: LED channel count; must be ≥ 3.
- R, 8: PWM resolution in bits.
- DVSR, 4882: 32-bit prescaler divisor; one PWM tick every DVSR clocks (0 behaves as 1).
- STEP_THRESH, 2_500_000: clocks per pattern step; must be ≥ 1.
- NSW, 4: switch input width; must be ≥ 4 (bits above 3 are ignored).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw  in  NSW  mode switches, asynchronous to clk.
- led  out  CH  PWM LED outputs.
- servo_out  out  1  servo PWM output.
- active_mode  out  3  currently applied mode: 0 off, 1 linear, 2 breathe, 3 rainbow, 4 servo.
- period_start  out  1  one-clock pulse when the PWM counter wraps to 0.

## Operation
- **Switch sync and decode:** sw passes through a 2-flop synchroniser. Priority decode gives the requested mode: sw[0]→1, else sw[1]→2, else sw[2]→3, else sw[3]→4, else 0.
- **Prescaler:** a 32-bit counter runs 0..DVSR-1. tick = 1 for the cycle in which the count equals DVSR-1.
- **PWM counter:** cnt (R bits) increments on tick and wraps from 2^R-1 to 0. period_start = tick && cnt==2^R-1.
- **Step timer:** counts 0..STEP_THRESH-1; step is pulsed on the last count. The timer is cleared on a mode change.
- **Mode apply:** on period_start, if the requested mode ≠ active_mode:
  - active_mode ← requested mode;
  - level ← 0, dir ← up, seg ← 0;
  - step timer ← 0;
  - all shadow duties ← 0.
- **Pattern engine:** acts on step only. MAX = 2^R-1.
  - Linear: level+1, wrapping MAX→0. shadow[0] = level.
  - Breathe and servo: triangle. Going up, MAX is followed by MAX-1 (dir flips down). Going down, 0 is followed by 1 (dir flips up). Breathe drives shadow[CH-1] = level; servo drives the servo shadow = level.
  - Rainbow: seg ∈ {0,1,2}, pos = level. Channel c = seg falls as MAX-pos; channel (seg+1) mod 3 rises as pos; the third channel is 0. pos runs 0..MAX. At pos = MAX, the next step sets pos ← 0 and seg ← seg+1, with seg wrapping 2→0.
  - Off: no state change.
- **Shadow registers:** channels not driven by the active mode hold 0. Channels CH..3 and above are always 0.
- **Duty load:** active duties are loaded from the shadow registers only on period_start.
- **Compare:** led[i] ← (cnt < duty[i]) and servo_out ← (cnt < duty_servo), both registered.
  - duty 0 gives constant low.
  - duty MAX gives high for MAX of the 2^R counts.
- **Outputs outside their mode:** servo_out is 0 in every mode except 4, and led is all 0 in modes 0 and 4.

## Timing
- **Reset:** asserting rst_n immediately (asynchronously) clears:
  - led, servo_out, period_start, active_mode;
  - all counters, level, seg, duties, and the synchroniser flops;
  - dir ← up.
- **Reset release:** cnt first increments DVSR clocks after rst_n deasserts.
- **Mode latency:** a sw change reaches the decoder after 2 clocks. It is applied at the first period_start after that and visible on active_mode the following cycle. Worst case is 2 + DVSR·2^R + 1 clocks.
- **Simultaneous mode change and step:** the mode change wins and the step is discarded.
- **Step versus period_start:** a step updates only the shadow registers, so a step landing on the same clock as period_start reaches the outputs one period later.
- **Output latency:** output bits change 1 clock after cnt changes; the duty used is the one loaded at the most recent wrap.
- **Mid-period switching:** sw changes in the middle of a period never shorten or extend the current pulse.
- **Reset mid-pulse:** the output drops to 0 asynchronously and restarts from mode 0.

## Test plan
All scenarios use R=3, DVSR=2, STEP_THRESH=4, CH=3, so one period is 16 clocks.

1. **Reset:** assert rst_n=0 while led[0] is high in linear mode → led, servo_out, and active_mode are 0 within the same cycle. After release with sw=0001, active_mode=1 after the first period_start.
2. **Linear ramp:** sw=0001, run 8 steps → led[0] high-time per period follows 0,2,4,…,14 clocks as level goes 0..7, then returns to 0 after wrap; led[1] and led[2] stay 0.
3. **Priority:** sw=0110 → active_mode=2. Only led[2] pulses, and level follows 0,1,…,7,6,5,…,0,1.
4. **Glitch-free switch:** change sw from 0001 to 1000 at cnt=3 with duty 5 → led[0] completes its 10-clock pulse, active_mode=4 after the wrap, led=0, servo_out=0 until the first step, and servo_out is never high outside mode 4.
5. **Rainbow wrap:** sw=0100, run 24 steps → led[0] falls 7→0 while led[1] rises, then led[1] falls while led[2] rises, then led[2] falls while led[0] rises. Step 24 returns to seg=0, pos=0 with led[0] at duty 7.
6. **Collision:** engineer a step on the same clock as a mode-change period_start → level stays 0 and the step timer restarts, so the first step comes 4 clocks later.

Source files
------------

// File: rtl/pwm_mode_ctrl.sv
// Multi-channel PWM pattern controller: prescaler, R-bit PWM counter, pattern engine
// (linear / breathe / rainbow / servo) and registered per-channel comparators.
module pwm_mode_ctrl #(
    parameter int          CH          = 3,
    parameter int          R           = 8,
    parameter int unsigned DVSR        = 4882,
    parameter int unsigned STEP_THRESH = 2_500_000,
    parameter int          NSW         = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NSW-1:0] sw,
    output logic [CH-1:0]  led,
    output logic           servo_out,
    output logic [2:0]     active_mode,
    output logic           period_start
);

    localparam logic [2:0] MODE_OFF = 3'd0;
    localparam logic [2:0] MODE_LIN = 3'd1;
    localparam logic [2:0] MODE_BRE = 3'd2;
    localparam logic [2:0] MODE_RBW = 3'd3;
    localparam logic [2:0] MODE_SRV = 3'd4;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam logic [R-1:0] MAX       = {R{1'b1}};
    localparam logic [R-1:0] ONE       = R'(1);
    localparam logic [31:0]  DV_LAST   = (DVSR == 0) ? 32'd0 : 32'(DVSR - 1);
    localparam logic [31:0]  STEP_LAST = 32'(STEP_THRESH - 1);

    // only the low four switches select a mode
    logic [3:0] sw_meta_q, sw_sync_q;

    if (NSW > 4) begin : g_sw_hi
        logic unused_sw_hi;
        assign unused_sw_hi = ^sw[NSW-1:4];
    end

    logic [31:0]  pre_q, pre_d;
    logic [R-1:0] cnt_q, cnt_d;
    logic [31:0]  step_cnt_q, step_cnt_d;
    logic [2:0]   mode_q, mode_d;
    logic [R-1:0] level_q, level_d;
    logic         dir_q, dir_d;
    logic [1:0]   seg_q, seg_d;
    logic [R-1:0] shadow_q [CH];
    logic [R-1:0] shadow_d [CH];
    logic [R-1:0] shadow_srv_q, shadow_srv_d;
    logic [R-1:0] duty_q [CH];
    logic [R-1:0] duty_d [CH];
    logic [R-1:0] duty_srv_q, duty_srv_d;
    logic [CH-1:0] led_q, led_d;
    logic         servo_q, servo_d;

    logic         tick;
    logic         step;
    logic         mode_change;
    logic [2:0]   req_mode;
    logic         led_en;

    logic [R-1:0] tri_level;
    logic         tri_dir;
    logic         rb_wrap;
    logic [R-1:0] rb_pos;
    logic [1:0]   rb_seg;
    logic [1:0]   rb_rise;

    assign tick         = (pre_q == DV_LAST);
    assign period_start = tick && (cnt_q == MAX);
    assign step         = (step_cnt_q == STEP_LAST);
    assign mode_change  = period_start && (req_mode != mode_q);

    always_comb begin
        if (sw_sync_q[0])      req_mode = MODE_LIN;
        else if (sw_sync_q[1]) req_mode = MODE_BRE;
        else if (sw_sync_q[2]) req_mode = MODE_RBW;
        else if (sw_sync_q[3]) req_mode = MODE_SRV;
        else                   req_mode = MODE_OFF;
    end

    // a mode change also restarts the step timer, swallowing a coincident step
    always_comb begin
        pre_d      = tick ? 32'd0 : pre_q + 32'd1;
        cnt_d      = tick ? cnt_q + ONE : cnt_q;
        step_cnt_d = (mode_change || step) ? 32'd0 : step_cnt_q + 32'd1;
        mode_d     = mode_change ? req_mode : mode_q;
    end

    // triangle: bounce off both ends without repeating the end value
    always_comb begin
        tri_level = level_q;
        tri_dir   = dir_q;
        if (dir_q == DIR_UP) begin
            if (level_q == MAX) begin
                tri_level = MAX - ONE;
                tri_dir   = DIR_DN;
            end else begin
                tri_level = level_q + ONE;
            end
        end else begin
            if (level_q == '0) begin
                tri_level = ONE;
                tri_dir   = DIR_UP;
            end else begin
                tri_level = level_q - ONE;
            end
        end
    end

    always_comb begin
        rb_wrap = (level_q == MAX);
        rb_pos  = rb_wrap ? '0 : level_q + ONE;
        if (rb_wrap) rb_seg = (seg_q == 2'd2) ? 2'd0 : seg_q + 2'd1;
        else         rb_seg = seg_q;
        rb_rise = (rb_seg == 2'd2) ? 2'd0 : rb_seg + 2'd1;
    end

    always_comb begin
        level_d      = level_q;
        dir_d        = dir_q;
        seg_d        = seg_q;
        shadow_srv_d = shadow_srv_q;
        for (int c = 0; c < CH; c++) shadow_d[c] = shadow_q[c];
        if (mode_change) begin
            level_d      = '0;
            dir_d        = DIR_UP;
            seg_d        = 2'd0;
            shadow_srv_d = '0;
            for (int c = 0; c < CH; c++) shadow_d[c] = '0;
        end else if (step) begin
            case (mode_q)
                MODE_LIN: begin
                    level_d     = level_q + ONE;
                    shadow_d[0] = level_q + ONE;
                end
                MODE_BRE: begin
                    level_d        = tri_level;
                    dir_d          = tri_dir;
                    shadow_d[CH-1] = tri_level;
                end
                MODE_SRV: begin
                    level_d      = tri_level;
                    dir_d        = tri_dir;
                    shadow_srv_d = tri_level;
                end
                MODE_RBW: begin
                    level_d = rb_pos;
                    seg_d   = rb_seg;
                    for (int c = 0; c < CH; c++) begin
                        if (c == int'(rb_seg))       shadow_d[c] = MAX - rb_pos;
                        else if (c == int'(rb_rise)) shadow_d[c] = rb_pos;
                        else                         shadow_d[c] = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // duties change only at the wrap; a new mode starts from dark outputs
    always_comb begin
        duty_srv_d = duty_srv_q;
        for (int c = 0; c < CH; c++) duty_d[c] = duty_q[c];
        if (period_start) begin
            duty_srv_d = mode_change ? '0 : shadow_srv_q;
            for (int c = 0; c < CH; c++) duty_d[c] = mode_change ? '0 : shadow_q[c];
        end
    end

    assign led_en = (mode_q != MODE_OFF) && (mode_q != MODE_SRV);

    genvar gi;
    for (gi = 0; gi < CH; gi++) begin : g_cmp
        assign led_d[gi] = led_en && (cnt_q < duty_q[gi]);
    end

    assign servo_d = (mode_q == MODE_SRV) && (cnt_q < duty_srv_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            pre_q        <= '0;
            cnt_q        <= '0;
            step_cnt_q   <= '0;
            mode_q       <= MODE_OFF;
            level_q      <= '0;
            dir_q        <= DIR_UP;
            seg_q        <= 2'd0;
            shadow_srv_q <= '0;
            duty_srv_q   <= '0;
            led_q        <= '0;
            servo_q      <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                shadow_q[c] <= '0;
                duty_q[c]   <= '0;
            end
        end else begin
            sw_meta_q    <= sw[3:0];
            sw_sync_q    <= sw_meta_q;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            step_cnt_q   <= step_cnt_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            dir_q        <= dir_d;
            seg_q        <= seg_d;
            shadow_srv_q <= shadow_srv_d;
            duty_srv_q   <= duty_srv_d;
            led_q        <= led_d;
            servo_q      <= servo_d;
            for (int c = 0; c < CH; c++) begin
                shadow_q[c] <= shadow_d[c];
                duty_q[c]   <= duty_d[c];
            end
        end
    end

    assign led         = led_q;
    assign servo_out   = servo_q;
    assign active_mode = mode_q;

endmodule
